button_debouncer: RTL and testbench

- Conditions the raw push-button inputs before they reach the button PIO input port.
- Per button: 2-flop synchronizer, stability-counter debounce, polarity normalization (1 = pressed).
- Produces one-cycle press/release pulses for the interrupt/edge logic.
- Instantiated in the top level between the board key pins and the PIO in_port.

---
 rtl/button_pkg.sv | 13 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/button_debouncer.sv | 56 +++++
 tb/tb_button_debouncer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
// The optional sticky-press latch is enabled by defining BUTTON_STICKY_PRESS_EN.
package button_pkg;

    localparam int DEFAULT_N_BUTTONS       = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Counter only needs to reach cycles-1, but the width is kept at clog2(cycles+1).
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, normalized
// debounced level and registered press/release pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          lvl;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign lvl = s2_q ^ ACTIVE_LOW;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (lvl != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = lvl;
                press_d   = lvl;
                release_d = ~lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: synchronizer resets to the idle pin level so reset release cannot look like a press.
            s1_q      <= ACTIVE_LOW;
            s2_q      <= ACTIVE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so s2_q takes the old s1_q, giving two real flop stages.
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw key pins into pressed-high levels plus edge pulses.
// Defining BUTTON_STICKY_PRESS_EN adds per-button press_latched / clear_latch.
module button_debouncer
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = DEFAULT_N_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_db,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
`ifdef BUTTON_STICKY_PRESS_EN
    ,
    output logic [N_BUTTONS-1:0] press_latched,
    input  logic [N_BUTTONS-1:0] clear_latch
`endif
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw_i     (buttons_raw[i]),
            .level_o   (buttons_db[i]),
            .press_o   (press_pulse[i]),
            .release_o (release_pulse[i])
        );
    end

`ifdef BUTTON_STICKY_PRESS_EN
    logic [N_BUTTONS-1:0] latched_q, latched_d;

    // A new press in the same cycle as a clear keeps the latch set.
    assign latched_d = (latched_q & ~clear_latch) | press_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latched_q <= '0;
        end else begin
            latched_q <= latched_d;
        end
    end

    assign press_latched = latched_q;
`else
    // Default build: no sticky state, channels drive the outputs directly.
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized scoreboard bench for button_debouncer (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1).
// Also exercises press_latched/clear_latch when BUTTON_STICKY_PRESS_EN is defined.
module tb_button_debouncer;

    localparam int N  = 4;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] buttons_raw = '1;
    logic [N-1:0] buttons_db, press_pulse, release_pulse;
`ifdef BUTTON_STICKY_PRESS_EN
    logic [N-1:0] press_latched;
    logic [N-1:0] clear_latch = '0;
`endif

    always #5 clk = ~clk;

    button_debouncer #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons_raw   (buttons_raw),
        .buttons_db    (buttons_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
`ifdef BUTTON_STICKY_PRESS_EN
        ,
        .press_latched (press_latched),
        .clear_latch   (clear_latch)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a pressed-high sample history per button. The debounced
    // level flips once the DC samples ending two edges ago all disagree with it.
    typedef struct {
        int           cyc;
        logic [N-1:0] db;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } ev_t;

    ev_t          sb[$];
    ev_t          ev, got;
    bit           hist [N][$];
    logic [N-1:0] m_db = '0, m_press = '0, m_latch = '0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i].delete();
            repeat (DC + 2) hist[i].push_back(1'b0);
        end
        m_db    = '0;
        m_press = '0;
        m_latch = '0;
        sb.delete();
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            logic [N-1:0] new_db;
            bit           stable;
            cyc++;
`ifdef BUTTON_STICKY_PRESS_EN
            m_latch = (m_latch & ~clear_latch) | m_press;
`endif
            new_db = m_db;
            for (int i = 0; i < N; i++) begin
                hist[i].push_back(!buttons_raw[i]);
                void'(hist[i].pop_front());
                stable = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[i][k] == m_db[i]) stable = 1'b0;
                if (stable) new_db[i] = ~m_db[i];
            end
            m_press = new_db & ~m_db;
            if (new_db != m_db) begin
                ev.cyc   = cyc;
                ev.db    = new_db;
                ev.press = m_press;
                ev.rel   = ~new_db & m_db;
                sb.push_back(ev);
            end
            m_db = new_db;
        end
    end

    // Monitor: a pulse on the outputs pops the scoreboard entry for this cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                got = sb.pop_front();
                check("edge_db", buttons_db, got.db);
                check("press_pulse", press_pulse, got.press);
                check("release_pulse", release_pulse, got.rel);
            end else if ((press_pulse | release_pulse) != '0) begin
                check("spurious_pulse", {press_pulse, release_pulse}, '0);
            end
            check("db_level", buttons_db, m_db);
`ifdef BUTTON_STICKY_PRESS_EN
            check("latched_level", press_latched, m_latch);
`endif
        end
    end

    // Counts falling edges until the selected pulse shows up on any masked bit.
    task automatic wait_pulse(input bit rel, input logic [N-1:0] mask, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((rel ? release_pulse : press_pulse) & mask) == '0) && n < 40);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_db", buttons_db, '0);
        check("idle_pulses", {press_pulse, release_pulse}, '0);

        #1 buttons_raw[0] = 1'b0;
        wait_pulse(1'b0, 4'b0001, n);
        check("press0_latency", n, 10);
        check("press0_db", buttons_db, 4'b0001);
        @(negedge clk);
        check("press0_one_cycle", press_pulse, '0);
`ifdef BUTTON_STICKY_PRESS_EN
        check("sticky_after_press", press_latched[0], 1'b1);
`endif

        repeat (3) begin
            #1 buttons_raw[1] = 1'b0;
            repeat (5) @(negedge clk);
            #1 buttons_raw[1] = 1'b1;
            repeat (5) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("glitch_db1", buttons_db[1], 1'b0);

        #1 buttons_raw[3:2] = 2'b00;
        repeat (12) @(negedge clk);
        check("press23_db", buttons_db, 4'b1101);
        #1 buttons_raw[3:2] = 2'b11;
        wait_pulse(1'b1, 4'b1100, n);
        check("release23_latency", n, 10);
        check("release23_pulse", release_pulse, 4'b1100);
        check("release23_db", buttons_db, 4'b0001);

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("rst_debounced_outputs", {buttons_db, press_pulse, release_pulse}, '0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        wait_pulse(1'b0, 4'b0001, n);
        check("rst_requalify_latency", n, 10);

        #1 buttons_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        #1 buttons_raw[0] = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("rst_midcount_outputs", {buttons_db, press_pulse, release_pulse}, '0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        wait_pulse(1'b0, 4'b0001, n);
        check("rst_midcount_latency", n, 10);

`ifdef BUTTON_STICKY_PRESS_EN
        #1 buttons_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        #1 clear_latch = '1;
        @(negedge clk);
        #1 clear_latch = '0;
        @(negedge clk);
        check("sticky_cleared", press_latched, '0);
        #1 buttons_raw[0] = 1'b0;
        wait_pulse(1'b0, 4'b0001, n);
        #1 clear_latch[0] = 1'b1;
        @(negedge clk);
        check("sticky_set_wins", press_latched[0], 1'b1);
        @(negedge clk);
        check("sticky_clear_alone", press_latched[0], 1'b0);
        #1 clear_latch[0] = 1'b0;
`endif

        repeat (3000) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 9) == 0)
                buttons_raw[$urandom_range(0, N - 1)] ^= 1'b1;
`ifdef BUTTON_STICKY_PRESS_EN
            clear_latch = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
        end

        #1 buttons_raw = '1;
`ifdef BUTTON_STICKY_PRESS_EN
        clear_latch = '0;
`endif
        repeat (30) @(negedge clk);
        check("final_db", buttons_db, '0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
